vid_frame_capture: RTL and testbench

Synthesizable video sink that captures one or more frames from a vsync/hsync/de/24-bit pixel stream. This is the same stream that the PPM file read model produces. Each pixel is written to a frame-buffer write port at a linear address. At end of frame the block reports the measured resolution, a pixel checksum and error flags. It sits at the tail of the video pipeline, feeding the frame buffer that a testbench or host dumps back to PPM.

---
 rtl/vid_frame_capture.sv | 149 ++++++++++++++
 tb/tb_vid_frame_capture.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_frame_capture.sv
// Video frame capture sink: writes each active pixel of a vsync/de stream to a
// frame-buffer write port at its linear index, and reports per-frame resolution,
// pixel checksum and error flags at end of frame.
module vid_frame_capture #(
  parameter int unsigned HRES   = 320,
  parameter int unsigned VRES   = 240,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_capture_en,
  input  logic              i_vsync,
  input  logic              i_hsync,
  input  logic              i_de,
  input  logic [23:0]       i_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [23:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_meas_hres,
  output logic [15:0]       o_meas_vres,
  output logic [31:0]       o_pix_sum,
  output logic              o_err_size,
  output logic              o_err_ovf
);

  localparam logic [31:0] NumPix = 32'(HRES * VRES);
  localparam logic [15:0] HresW  = 16'(HRES);
  localparam logic [15:0] VresW  = 16'(VRES);

  typedef enum logic [1:0] {StIdle, StArm, StCapture, StDone} state_e;

  state_e      state_q;
  logic        vsync_q;
  logic        de_q;
  logic [31:0] pix_cnt_q;
  logic [15:0] line_cnt_q;
  logic [15:0] h_cnt_q;
  logic [15:0] first_len_q;
  logic [31:0] sum_q;
  logic        size_acc_q;
  logic        ovf_acc_q;

  logic        vsync_fall;
  logic        vsync_rise;
  logic        de_fall;
  logic [9:0]  pix_rgb;
  logic        unused_hsync;

  assign vsync_fall   = vsync_q & ~i_vsync;
  assign vsync_rise   = ~vsync_q & i_vsync;
  assign de_fall      = de_q & ~i_de;
  assign pix_rgb      = 10'(i_data[23:16]) + 10'(i_data[15:8]) + 10'(i_data[7:0]);
  // hsync carries no information for capture; lines are delimited by de.
  assign unused_hsync = i_hsync;

  // Busy is a pure decode of the registered state.
  assign o_busy = (state_q == StArm) || (state_q == StCapture);

  // Capture FSM with counters, accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vsync_q      <= 1'b0;
      de_q         <= 1'b0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      h_cnt_q      <= '0;
      first_len_q  <= '0;
      sum_q        <= '0;
      size_acc_q   <= 1'b0;
      ovf_acc_q    <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      o_meas_hres  <= '0;
      o_meas_vres  <= '0;
      o_pix_sum    <= '0;
      o_err_size   <= 1'b0;
      o_err_ovf    <= 1'b0;
    end else begin
      vsync_q      <= i_vsync;
      de_q         <= i_de;
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_capture_en) state_q <= StArm;
        end
        StArm: begin
          if (!i_capture_en) begin
            state_q <= StIdle;
          end else if (vsync_fall) begin
            // Only whole frames are captured: start from a clean slate here.
            state_q     <= StCapture;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            h_cnt_q     <= '0;
            first_len_q <= '0;
            sum_q       <= '0;
            size_acc_q  <= 1'b0;
            ovf_acc_q   <= 1'b0;
          end
        end
        StCapture: begin
          if (i_de) begin
            if (pix_cnt_q < NumPix) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= pix_cnt_q[ADDR_W-1:0];
              o_wr_data <= i_data;
              sum_q     <= sum_q + 32'(pix_rgb);
            end else begin
              ovf_acc_q <= 1'b1;
            end
            pix_cnt_q <= pix_cnt_q + 32'd1;
            h_cnt_q   <= h_cnt_q + 16'd1;
          end
          // de_fall implies i_de is low, so this never collides with the block above.
          if (de_fall) begin
            line_cnt_q <= line_cnt_q + 16'd1;
            if (line_cnt_q == 16'd0) begin
              first_len_q <= h_cnt_q;
            end else if (h_cnt_q != first_len_q) begin
              size_acc_q <= 1'b1;
            end
            h_cnt_q <= '0;
          end
          if (vsync_rise) state_q <= StDone;
        end
        StDone: begin
          o_frame_done <= 1'b1;
          o_meas_hres  <= first_len_q;
          o_meas_vres  <= line_cnt_q;
          o_pix_sum    <= sum_q;
          o_err_size   <= size_acc_q | (first_len_q != HresW) | (line_cnt_q != VresW);
          o_err_ovf    <= ovf_acc_q;
          o_frame_cnt  <= o_frame_cnt + 16'd1;
          state_q      <= i_capture_en ? StArm : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vid_frame_capture.sv
// Self-checking bench for vid_frame_capture with a 4x3 frame geometry.
module tb_vid_frame_capture;

  localparam int unsigned HRES   = 4;
  localparam int unsigned VRES   = 3;
  localparam int unsigned ADDR_W = 4;
  localparam int          NPIX   = HRES * VRES;

  typedef int lens_t [8];

  logic              clk;
  logic              rst_n;
  logic              i_capture_en;
  logic              i_vsync;
  logic              i_hsync;
  logic              i_de;
  logic [23:0]       i_data;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [23:0]       o_wr_data;
  logic              o_busy;
  logic              o_frame_done;
  logic [15:0]       o_frame_cnt;
  logic [15:0]       o_meas_hres;
  logic [15:0]       o_meas_vres;
  logic [31:0]       o_pix_sum;
  logic              o_err_size;
  logic              o_err_ovf;
  logic [112:0]      all_out;

  vid_frame_capture #(
    .HRES   (HRES),
    .VRES   (VRES),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_capture_en (i_capture_en),
    .i_vsync      (i_vsync),
    .i_hsync      (i_hsync),
    .i_de         (i_de),
    .i_data       (i_data),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_frame_cnt  (o_frame_cnt),
    .o_meas_hres  (o_meas_hres),
    .o_meas_vres  (o_meas_vres),
    .o_pix_sum    (o_pix_sum),
    .o_err_size   (o_err_size),
    .o_err_ovf    (o_err_ovf)
  );

  assign all_out = {o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_done, o_frame_cnt,
                    o_meas_hres, o_meas_vres, o_pix_sum, o_err_size, o_err_ovf};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write and frame-done monitor, sampled on the falling edge.
  logic [ADDR_W-1:0] mon_addr [$];
  logic [23:0]       mon_data [$];
  int                mon_cyc  [$];
  int                done_cnt = 0;
  always @(negedge clk) begin
    if (o_wr_en) begin
      mon_addr.push_back(o_wr_addr);
      mon_data.push_back(o_wr_data);
      mon_cyc.push_back(cyc);
    end
    if (o_frame_done) done_cnt <= done_cnt + 1;
  end

  logic [23:0] drv_data [$];
  int          drv_cyc  [$];
  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int base_w = 0;
  int base_done = 0;

  task automatic mark_base();
    base_w    = mon_addr.size();
    base_done = done_cnt;
    drv_data.delete();
    drv_cyc.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; i_vsync = 1'b1; i_de = 1'b0; i_hsync = 1'b0; i_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_frames = 0;
    @(negedge clk);
  endtask

  // Drives one frame. act at line act_line: 1 enable, 2 disable, 3 one-cycle reset.
  task automatic drive_frame(input int nlines, input lens_t lens, input bit ramp,
                             input int act_line, input int act);
    int idx = 0;
    #1;
    mark_base();
    @(negedge clk);
    i_vsync = 1'b1; i_de = 1'b0;
    repeat (2) @(negedge clk);
    i_vsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < nlines; l++) begin
      if (l == act_line) begin
        if (act == 1) i_capture_en = 1'b1;
        if (act == 2) i_capture_en = 1'b0;
        if (act == 3) begin
          rst_n = 1'b0;
          #1;
          checks++;
          if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_frame_outputs: got %h expected 0", all_out);
          end
          exp_frames = 0;
          mark_base();
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
      for (int p = 0; p < lens[l]; p++) begin
        i_de   = 1'b1;
        i_data = ramp ? 24'(idx * 32'h010101) : 24'($urandom);
        drv_data.push_back(i_data);
        drv_cyc.push_back(cyc);
        idx++;
        @(negedge clk);
      end
      i_de = 1'b0; i_hsync = 1'b1;
      @(negedge clk);
      i_hsync = 1'b0;
      repeat (2) @(negedge clk);
    end
    i_vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Frame scoreboard: expected results derived from line lengths and driven pixels.
  task automatic score_frame(input string name, input bit captured, input int nlines,
                             input lens_t lens);
    int total = 0, nl = 0, first = 0, nw, got_w;
    bit nonuni = 0, exp_size, exp_ovf;
    logic [31:0] sum = '0;
    for (int l = 0; l < nlines; l++) begin
      if (lens[l] > 0) begin
        if (nl == 0) first = lens[l];
        else if (lens[l] != first) nonuni = 1'b1;
        nl++;
        total += lens[l];
      end
    end
    nw = captured ? ((total < NPIX) ? total : NPIX) : 0;
    for (int i = 0; i < nw; i++)
      sum += 32'(drv_data[i][23:16]) + 32'(drv_data[i][15:8]) + 32'(drv_data[i][7:0]);
    exp_size = nonuni || (first != HRES) || (nl != VRES);
    exp_ovf  = (total > NPIX);
    if (captured) exp_frames++;

    got_w = mon_addr.size() - base_w;
    checks++;
    if (got_w != nw) begin
      errors++;
      $display("FAIL %s wr_count: got %0d expected %0d", name, got_w, nw);
    end
    for (int i = 0; i < nw && i < got_w; i++) begin
      checks++;
      if (int'(mon_addr[base_w+i]) != i || mon_data[base_w+i] !== drv_data[i] ||
          mon_cyc[base_w+i] != drv_cyc[i] + 1) begin
        errors++;
        $display("FAIL %s write[%0d]: got addr %0d data %h cyc %0d expected addr %0d data %h cyc %0d",
                 name, i, mon_addr[base_w+i], mon_data[base_w+i], mon_cyc[base_w+i],
                 i, drv_data[i], drv_cyc[i] + 1);
      end
    end
    checks++;
    if (done_cnt - base_done != (captured ? 1 : 0)) begin
      errors++;
      $display("FAIL %s frame_done_pulses: got %0d expected %0d", name, done_cnt - base_done,
               captured ? 1 : 0);
    end
    checks++;
    if (int'(o_frame_cnt) != exp_frames) begin
      errors++;
      $display("FAIL %s frame_cnt: got %0d expected %0d", name, o_frame_cnt, exp_frames);
    end
    if (captured) begin
      checks++;
      if (int'(o_meas_hres) != first || int'(o_meas_vres) != nl) begin
        errors++;
        $display("FAIL %s meas: got %0d/%0d expected %0d/%0d", name, o_meas_hres, o_meas_vres,
                 first, nl);
      end
      checks++;
      if (o_pix_sum !== sum) begin
        errors++;
        $display("FAIL %s pix_sum: got %0d expected %0d", name, o_pix_sum, sum);
      end
      checks++;
      if (o_err_size !== exp_size || o_err_ovf !== exp_ovf) begin
        errors++;
        $display("FAIL %s errs: got size %b ovf %b expected size %b ovf %b", name, o_err_size,
                 o_err_ovf, exp_size, exp_ovf);
      end
    end
  endtask

  task automatic test_reset();
    i_capture_en = 1'b0;
    apply_reset();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_basic();
    lens_t lens = '{4, 4, 4, 0, 0, 0, 0, 0};
    apply_reset();
    i_capture_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_armed: got %b expected 1", o_busy);
    end
    drive_frame(3, lens, 1'b1, -1, 0);
    score_frame("basic", 1'b1, 3, lens);
  endtask

  task automatic test_mid_frame_enable();
    lens_t lens = '{4, 4, 4, 0, 0, 0, 0, 0};
    i_capture_en = 1'b0;
    apply_reset();
    drive_frame(3, lens, 1'b0, 1, 1);
    score_frame("midenable_partial", 1'b0, 3, lens);
    drive_frame(3, lens, 1'b0, -1, 0);
    score_frame("midenable_full", 1'b1, 3, lens);
  endtask

  task automatic test_overflow();
    lens_t lens = '{4, 4, 4, 4, 0, 0, 0, 0};
    apply_reset();
    i_capture_en = 1'b1;
    drive_frame(4, lens, 1'b0, -1, 0);
    score_frame("overflow", 1'b1, 4, lens);
  endtask

  task automatic test_nonuniform();
    lens_t lens = '{4, 3, 4, 0, 0, 0, 0, 0};
    apply_reset();
    i_capture_en = 1'b1;
    drive_frame(3, lens, 1'b0, -1, 0);
    score_frame("nonuniform", 1'b1, 3, lens);
  endtask

  task automatic test_disable_during_capture();
    lens_t lens = '{4, 4, 4, 0, 0, 0, 0, 0};
    apply_reset();
    i_capture_en = 1'b1;
    drive_frame(3, lens, 1'b0, 1, 2);
    score_frame("disable_current", 1'b1, 3, lens);
    drive_frame(3, lens, 1'b0, -1, 0);
    score_frame("disable_next", 1'b0, 3, lens);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL disable_busy: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    lens_t lens = '{4, 4, 4, 0, 0, 0, 0, 0};
    apply_reset();
    i_capture_en = 1'b1;
    drive_frame(3, lens, 1'b0, 1, 3);
    score_frame("rstmid_aborted", 1'b0, 3, lens);
    drive_frame(3, lens, 1'b0, -1, 0);
    score_frame("rstmid_next", 1'b1, 3, lens);
  endtask

  task automatic test_back_to_back_random();
    lens_t lens = '{0, 0, 0, 0, 0, 0, 0, 0};
    int nlines;
    apply_reset();
    i_capture_en = 1'b1;
    drive_frame(0, lens, 1'b0, -1, 0);
    score_frame("empty", 1'b1, 0, lens);
    for (int f = 0; f < 6; f++) begin
      nlines = $urandom_range(0, 5);
      for (int l = 0; l < 8; l++) lens[l] = $urandom_range(0, 5);
      drive_frame(nlines, lens, 1'b0, -1, 0);
      score_frame("random", 1'b1, nlines, lens);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_capture_en = 1'b0; i_vsync = 1'b1; i_hsync = 1'b0; i_de = 1'b0;
    i_data = '0;
    test_reset();
    test_basic();
    test_mid_frame_enable();
    test_overflow();
    test_nonuniform();
    test_disable_during_capture();
    test_reset_mid_frame();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
